// File: rtl/truth_table_extractor.sv
// Sweeps all 8 rows of a 3-input combinational circuit, majority-votes the
// settled output of each row and assembles the 8-bit truth-table code.
module truth_table_extractor #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       drive_in1,
  output logic       drive_in2,
  output logic       drive_in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       match,
  output logic       unstable
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    STORE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLES - 1);
  localparam logic [3:0] HALF        = 4'(SAMPLES / 2);

  state_t     state, state_nxt;
  logic [2:0] row;
  logic [7:0] settle_cnt;
  logic [3:0] sample_cnt;
  logic [3:0] ones;
  logic       first;
  logic       differ;
  logic [7:0] expected_q;
  logic [7:0] code_store;

  function automatic logic majority(input logic [3:0] count);
    return count > HALF;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  if (sample_cnt == SAMPLE_LAST) state_nxt = STORE;
      STORE:   state_nxt = (row == 3'd7) ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Row r lands in code[7-r]; for a 3-bit row, 7-r is simply ~r.
  always_comb begin
    code_store       = code;
    code_store[~row] = majority(ones);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drive_in1  <= 1'b0;
      drive_in2  <= 1'b0;
      drive_in3  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      code       <= 8'h00;
      match      <= 1'b0;
      unstable   <= 1'b0;
      row        <= 3'd0;
      settle_cnt <= 8'd0;
      sample_cnt <= 4'd0;
      ones       <= 4'd0;
      first      <= 1'b0;
      differ     <= 1'b0;
      expected_q <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            expected_q <= expected;
            code       <= 8'h00;
            match      <= 1'b0;
            unstable   <= 1'b0;
            row        <= 3'd0;
            busy       <= 1'b1;
          end
        end
        APPLY: begin
          {drive_in1, drive_in2, drive_in3} <= row;
          settle_cnt <= 8'd0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          sample_cnt <= 4'd0;
          ones       <= 4'd0;
          differ     <= 1'b0;
        end
        SAMPLE: begin
          sample_cnt <= sample_cnt + 4'd1;
          ones       <= ones + {3'b000, dut_out};
          if (sample_cnt == 4'd0)    first  <= dut_out;
          else if (dut_out != first) differ <= 1'b1;
        end
        STORE: begin
          code <= code_store;
          if (differ) unstable <= 1'b1;
          // match is resolved from the complete code so it is valid alongside done
          if (row == 3'd7) begin
            match <= (code_store == expected_q);
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            row <= row + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_extractor.sv
// Bench for truth_table_extractor: CUT modelled from a truth table or expression,
// with per-sample output flips, checked against a row/sample reference model.
module tb_truth_table_extractor;

  localparam int SC  = 4;
  localparam int SM  = 3;
  localparam int ROW = 2 + SC + SM;
  localparam int TOT = 8 * ROW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       drive_in1, drive_in2, drive_in3;
  logic       dut_out;
  logic       busy, done, match, unstable;
  logic [7:0] code;

  always #5 clk = ~clk;

  truth_table_extractor #(.SETTLE_CYCLES(SC), .SAMPLES(SM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
    .drive_in1(drive_in1), .drive_in2(drive_in2), .drive_in3(drive_in3),
    .dut_out(dut_out), .busy(busy), .done(done), .code(code),
    .match(match), .unstable(unstable)
  );

  // CUT model and sample-window fault injection
  int unsigned tcyc = 0;
  int unsigned t0 = 0;
  logic        sweep_on = 1'b0;
  logic        use_expr = 1'b1;
  logic [7:0]  cut_tt = 8'h00;
  logic [23:0] flips = 24'h0;
  logic [2:0]  drv;
  logic        base_bit;
  logic        flip;
  int unsigned ncyc;
  int unsigned fpos;

  always @(posedge clk) tcyc <= tcyc + 1;

  assign drv      = {drive_in1, drive_in2, drive_in3};
  assign base_bit = use_expr ? (drv[2] ^ (drv[1] | drv[0])) : cut_tt[3'd7 - drv];
  assign ncyc     = tcyc - t0;

  always_comb begin
    flip = 1'b0;
    fpos = ncyc % ROW;
    if (sweep_on && ncyc < TOT && fpos >= 1 + SC && fpos < 1 + SC + SM)
      flip = flips[(ncyc / ROW) * SM + (fpos - (1 + SC))];
  end

  assign dut_out = base_bit ^ flip;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: each row's samples are the ideal output XOR the flip pattern;
  // the row bit is whichever value the majority of samples show.
  task automatic model(output logic [7:0] rc, output logic ru);
    rc = 8'h00;
    ru = 1'b0;
    for (int r = 0; r < 8; r++) begin
      logic [2:0] rr;
      logic       b, s, f;
      int         hi, lo;
      rr = r[2:0];
      b  = use_expr ? (rr[2] ^ (rr[1] | rr[0])) : cut_tt[7 - r];
      hi = 0; lo = 0; f = 1'b0;
      for (int k = 0; k < SM; k++) begin
        s = b ^ flips[r * SM + k];
        if (s) hi++; else lo++;
        if (k == 0) f = s;
        else if (s != f) ru = 1'b1;
      end
      rc[7 - r] = (hi > lo);
    end
  endtask

  task automatic run_sweep(input logic [7:0] exp, input int restart_at);
    logic [7:0] rc;
    logic       ru;
    model(rc, ru);
    @(negedge clk);
    expected = exp;
    start    = 1'b1;
    @(posedge clk);
    #1;
    t0       = tcyc;
    sweep_on = 1'b1;
    start    = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
    for (int n = 0; n <= TOT; n++) begin
      @(negedge clk);
      if (n == restart_at) begin
        start    = 1'b1;
        expected = ~exp;
      end else if (n == restart_at + 1) begin
        start    = 1'b0;
        expected = exp;
      end
      if (n % ROW == 1 + SC) chk("drive_row", {29'd0, drv}, n / ROW);
      chk("done_timing", {31'd0, done}, (n == TOT) ? 1 : 0);
    end
    chk("code", {24'd0, code}, {24'd0, rc});
    chk("match", {31'd0, match}, (rc == exp) ? 1 : 0);
    chk("unstable", {31'd0, unstable}, {31'd0, ru});
    chk("busy_in_done", {31'd0, busy}, 0);
    sweep_on = 1'b0;
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("code_held", {24'd0, code}, {24'd0, rc});
  endtask

  initial begin
    logic [7:0]  rc;
    logic        ru;
    int unsigned d1, d2;
    int          seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_code", {24'd0, code}, 0);
    chk("rst_match_unst", {30'd0, match, unstable}, 0);
    chk("rst_drives", {29'd0, drv}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean 0x78 circuit
    use_expr = 1'b1; flips = 24'h0;
    run_sweep(8'h78, -1);
    chk("clean_code", {24'd0, code}, 32'h78);
    chk("clean_match", {31'd0, match}, 1);
    chk("idle_drives_hold", {29'd0, drv}, 7);

    // Mismatch, then match again
    run_sweep(8'h96, -1);
    chk("mismatch_match", {31'd0, match}, 0);
    run_sweep(8'h78, -1);
    chk("rematch_match", {31'd0, match}, 1);

    // Constant outputs
    use_expr = 1'b0; cut_tt = 8'h00;
    run_sweep(8'h00, -1);
    chk("const0_code", {24'd0, code}, 0);
    cut_tt = 8'hFF;
    run_sweep(8'hFF, -1);
    chk("const1_code", {24'd0, code}, 32'hFF);
    chk("const1_unst", {31'd0, unstable}, 0);

    // One glitched sample in row 4, then two
    use_expr = 1'b1;
    flips = 24'h0; flips[4 * SM + 1] = 1'b1;
    run_sweep(8'h78, -1);
    chk("glitch1_code", {24'd0, code}, 32'h78);
    chk("glitch1_unst", {31'd0, unstable}, 1);
    flips = 24'h0; flips[4 * SM + 0] = 1'b1; flips[4 * SM + 2] = 1'b1;
    run_sweep(8'h78, -1);
    chk("glitch2_code", {24'd0, code}, 32'h70);
    chk("glitch2_match", {31'd0, match}, 0);

    // Start pulsed mid-sweep is ignored; unstable cleared by new start
    flips = 24'h0;
    run_sweep(8'h78, 3 * ROW + 2);
    chk("restart_unst_cleared", {31'd0, unstable}, 0);

    // Reset during row 3 SETTLE
    @(negedge clk);
    expected = 8'h78; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3 * ROW + 3) @(negedge clk);
    chk("partial_code", {24'd0, code}, 32'h60);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_code", {24'd0, code}, 0);
    chk("abort_flags", {28'd0, busy, done, match, unstable}, 0);
    chk("abort_drives", {29'd0, drv}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < TOT + 20; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("no_done_after_abort", seen, 0);

    // Back-to-back sweeps with start held high
    @(negedge clk);
    expected = 8'h78; start = 1'b1;
    d1 = 0; d2 = 0;
    for (int i = 0; i < 3 * TOT; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = tcyc;
        else begin d2 = tcyc; break; end
      end
    end
    start = 1'b0;
    chk("b2b_second_done_seen", {31'd0, (d2 != 0)}, 1);
    chk("b2b_gap", d2 - d1, TOT + 2);
    chk("b2b_match", {31'd0, match}, 1);
    repeat (3) @(negedge clk);
    chk("b2b_idle", {31'd0, busy}, 0);

    // Randomized circuits and sample noise
    use_expr = 1'b0;
    for (int t = 0; t < 12; t++) begin
      cut_tt = 8'($urandom);
      for (int i = 0; i < 24; i++) flips[i] = ($urandom_range(0, 7) == 0);
      model(rc, ru);
      if ($urandom_range(0, 1) == 1) run_sweep(rc, -1);
      else run_sweep(8'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Sequential characterisation block, the reading end of the 3-input gate-level logic circuits the team synthesises.
- Drives all 8 input combinations into a combinational circuit under test (CUT), waits for settling, and samples the CUT output.
- Assembles the 8-bit truth-table hex code (the same code that names each circuit) and compares it against an expected code.
- Used in the self-checking harness to verify each generated netlist.

Parameters:
- SETTLE_CYCLES, 4: cycles between driving a row and the first sample of that row. Legal range 1..255.
- SAMPLES, 3: consecutive samples taken per row, resolved by majority vote. Must be odd, 1..15.

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request a sweep; accepted only in IDLE
- expected  input  8  expected truth-table code; latched when start is accepted
- drive_in1  output  1  CUT input in1 (row index bit 2, MSB)
- drive_in2  output  1  CUT input in2 (row index bit 1)
- drive_in3  output  1  CUT input in3 (row index bit 0)
- dut_out  input  1  CUT output; synchronous to clk, no internal synchroniser
- busy  output  1  high from start acceptance until DONE is entered
- done  output  1  one-cycle pulse when the code is complete
- code  output  8  extracted truth table; code[7-r] = CUT output at row r, where r = {in1,in2,in3}
- match  output  1  code == latched expected; valid when done is pulsed
- unstable  output  1  sticky; set if any row's samples disagree

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - drive_in1/2/3, busy, done, match and unstable go to 0; code goes to 8'h00.
  - Reset mid-sweep aborts immediately, with no done pulse.
- Row encoding: for in1 = in2 = in3 = 0 the output lands in code[7].
  - Example: out = in1 XOR (in2 | in3) yields 8'h78.
- States:
  - IDLE: waits for start.
  - APPLY: 1 cycle.
  - SETTLE: SETTLE_CYCLES cycles.
  - SAMPLE: SAMPLES cycles.
  - STORE: 1 cycle.
  - DONE: 1 cycle.
- IDLE -> APPLY when start is high:
  - Latch expected.
  - Clear code, match and unstable.
  - Set row to 0 and assert busy.
- APPLY: drive_in* are registered from row and hold stable until the next APPLY.
- SETTLE: a counter counts SETTLE_CYCLES; dut_out is ignored.
- SAMPLE:
  - Each cycle, add dut_out to a 4-bit ones counter.
  - Record whether any sample differs from the first sample.
- STORE:
  - code[7-row] <= (ones > SAMPLES/2).
  - If the samples disagreed, set unstable (it stays set until the next accepted start).
  - If row == 7, go to DONE; otherwise row <= row+1 and go to APPLY.
- DONE:
  - done = 1 for this cycle; match <= (code == expected), using the fully stored code.
  - busy drops on entry to DONE.
  - Next state is IDLE.
- Held values: code, match and unstable hold until the next accepted start or reset. Drives hold the last row (in1 = in2 = in3 = 1) in IDLE.
- Timing:
  - Cycles per row = 2 + SETTLE_CYCLES + SAMPLES.
  - done is high in the cycle that begins 8*(2+SETTLE_CYCLES+SAMPLES) edges after the edge that accepted start. With defaults that is 72.
- start while busy, or in the DONE cycle: ignored, with no effect on the running sweep.
- start held high continuously: a new sweep is accepted in the IDLE cycle after DONE, i.e. back-to-back sweeps.
- With SAMPLES = 1, unstable can never be set.

Test Plan:
- Clean 0x78 model: CUT models out = in1 ^ (in2 | in3), expected = 8'h78, start pulse.
  - Required: drives step through rows 0..7 in order.
  - done pulses exactly 72 edges after start; code = 8'h78, match = 1, unstable = 0.
- Mismatch: same CUT, expected = 8'h96.
  - Required: code = 8'h78, match = 0; next sweep with expected = 8'h78 gives match = 1.
- Constant CUT output: dut_out tied to 0, then to 1.
  - Required: code = 8'h00, then 8'hFF; unstable = 0 both times.
- Glitch: 0x78 CUT, force dut_out to 0 during one of 3 samples in row 4.
  - Required: code = 8'h78 (majority wins), unstable = 1.
  - Forcing 2 of 3 samples low instead gives code = 8'h70.
- Reset and start while busy:
  - Assert rst_n = 0 during row 3 SETTLE: all outputs 0 at the next edge, no done pulse.
  - Pulse start mid-sweep: no restart, done timing unchanged.
